// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : State encodings, default digit limits and clamp helper for the countdown timer.
// Revision : 1.0
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } timer_state_e;

  localparam int c_sec_tens_max_def = 5;
  localparam int c_digit_max_def    = 9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dn_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dn_digit
// Purpose  : One BCD down-counting digit with load, decrement enable, wrap limit and borrow-out.
// Revision : 1.0
// ============================================================================
module bcd_dn_digit (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic [3:0] limit,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;

  // Reset loads the (clamped) preset so the display is valid while rst_p is held.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_digit <= load_val;
    end else if (load) begin
      r_digit <= load_val;
    end else if (dec_en) begin
      r_digit <= (r_digit == 4'd0) ? limit : r_digit - 4'd1;
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec_en && (r_digit == 4'd0);

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_ctrl
// Purpose  : MM:SS BCD countdown timer with run/pause/done control and clamped preset.
// Revision : 1.0
// ============================================================================
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int SEC_TENS_MAX = c_sec_tens_max_def,
  parameter int DIGIT_MAX    = c_digit_max_def
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic [3:0] preset_mt,
  input  logic [3:0] preset_mo,
  input  logic [3:0] preset_st,
  input  logic [3:0] preset_so,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       running,
  output logic       done
);

  localparam logic [3:0] c_st_lim = 4'(SEC_TENS_MAX);
  localparam logic [3:0] c_dg_lim = 4'(DIGIT_MAX);

  timer_state_e r_state, w_next_state;
  logic         r_running, r_done;
  logic         w_load, w_dec, w_pre_nonzero, w_at_one;
  logic         w_so_borrow, w_st_borrow, w_mo_borrow, w_unused_mt_borrow;
  logic [3:0]   w_pre_mt, w_pre_mo, w_pre_st, w_pre_so;

  assign w_pre_mt = clamp_digit(preset_mt, c_dg_lim);
  assign w_pre_mo = clamp_digit(preset_mo, c_dg_lim);
  assign w_pre_st = clamp_digit(preset_st, c_st_lim);
  assign w_pre_so = clamp_digit(preset_so, c_dg_lim);

  assign w_pre_nonzero = |{w_pre_mt, w_pre_mo, w_pre_st, w_pre_so};
  assign w_at_one      = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    if (clear) begin
      w_next_state = IDLE;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_load = 1'b1;
          if (start_stop && w_pre_nonzero) w_next_state = RUN;
        end
        RUN: begin
          if (start_stop) begin
            w_next_state = PAUSE;
          end else if (tick) begin
            w_dec = 1'b1;
            if (w_at_one) w_next_state = DONE;
          end
        end
        PAUSE: if (start_stop) w_next_state = RUN;
        DONE:  if (start_stop) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == RUN);
      r_done    <= (w_next_state == DONE);
    end
  end

  assign state   = r_state;
  assign running = r_running;
  assign done    = r_done;

  bcd_dn_digit u_sec_ones (
    .clk(clk), .rst_p(rst_p), .load(w_load), .load_val(w_pre_so),
    .dec_en(w_dec), .limit(c_dg_lim), .digit(sec_ones), .borrow_out(w_so_borrow)
  );

  bcd_dn_digit u_sec_tens (
    .clk(clk), .rst_p(rst_p), .load(w_load), .load_val(w_pre_st),
    .dec_en(w_so_borrow), .limit(c_st_lim), .digit(sec_tens), .borrow_out(w_st_borrow)
  );

  bcd_dn_digit u_min_ones (
    .clk(clk), .rst_p(rst_p), .load(w_load), .load_val(w_pre_mo),
    .dec_en(w_st_borrow), .limit(c_dg_lim), .digit(min_ones), .borrow_out(w_mo_borrow)
  );

  // Counting stops at 00:00, so the most significant digit never borrows.
  bcd_dn_digit u_min_tens (
    .clk(clk), .rst_p(rst_p), .load(w_load), .load_val(w_pre_mt),
    .dec_en(w_mo_borrow), .limit(c_dg_lim), .digit(min_tens), .borrow_out(w_unused_mt_borrow)
  );

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_ctrl
// Purpose  : Directed and random checks of countdown_timer_ctrl against a seconds-count model.
// Revision : 1.0
// ============================================================================
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0, rst_p = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] preset_mt = 4'd0, preset_mo = 4'd0, preset_st = 4'd0, preset_so = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       running, done;

  int n_total = 0;
  int n_bad   = 0;
  int m_state = 0;  // 0 idle, 1 run, 2 pause, 3 done
  int m_secs  = 0;

  countdown_timer_ctrl dut (
    .clk(clk), .rst_p(rst_p), .tick(tick), .start_stop(start_stop), .clear(clear),
    .preset_mt(preset_mt), .preset_mo(preset_mo), .preset_st(preset_st), .preset_so(preset_so),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic int preset_secs();
    return (clampi(int'(preset_mt), 9) * 10 + clampi(int'(preset_mo), 9)) * 60
         + clampi(int'(preset_st), 5) * 10 + clampi(int'(preset_so), 9);
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".state"}, 32'(state), 32'(m_state));
    check_val({tag, ".running"}, 32'(running), 32'(m_state == 1));
    check_val({tag, ".done"}, 32'(done), 32'(m_state == 3));
    check_val({tag, ".digits"}, 32'(digits()), 32'(secs_to_bcd(m_secs)));
  endtask

  task automatic model_edge(input logic ss, input logic clr, input logic tk);
    int p;
    p = preset_secs();
    if (clr) begin
      m_state = 0;
      m_secs  = p;
    end else begin
      case (m_state)
        0: begin
          m_secs = p;
          if (ss && p != 0) m_state = 1;
        end
        1: begin
          if (ss) m_state = 2;
          else if (tk) begin
            m_secs--;
            if (m_secs == 0) m_state = 3;
          end
        end
        2: if (ss) m_state = 1;
        default: if (ss) m_state = 0;
      endcase
    end
  endtask

  task automatic step(input logic ss, input logic clr, input logic tk, input string tag);
    start_stop = ss;
    clear      = clr;
    tick       = tk;
    @(posedge clk);
    model_edge(ss, clr, tk);
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    tick       = 1'b0;
    check_all(tag);
  endtask

  task automatic set_preset(input int mt, input int mo, input int st, input int so);
    preset_mt = 4'(mt);
    preset_mo = 4'(mo);
    preset_st = 4'(st);
    preset_so = 4'(so);
  endtask

  // Asynchronous reset applied between clock edges; checked before any edge occurs.
  task automatic do_reset(input string tag);
    rst_p = 1'b1;
    #1;
    m_state = 0;
    m_secs  = preset_secs();
    check_all(tag);
    @(negedge clk);
    rst_p = 1'b0;
  endtask

  initial begin
    #2;
    set_preset(0, 0, 0, 3);
    do_reset("por");
    check_val("por_digits", 32'(digits()), 32'h0003);

    // 00:03 countdown to done
    step(1'b1, 1'b0, 1'b0, "t033_start");
    repeat (3) step(1'b0, 1'b0, 1'b1, "t033_tick");
    check_val("t033_done", 32'(done), 32'd1);
    check_val("t033_zero", 32'(digits()), 32'h0000);
    step(1'b0, 1'b0, 1'b1, "t033_hold");
    step(1'b1, 1'b0, 1'b0, "t033_ack");
    check_val("t033_idle", 32'(state), 32'd0);

    // multi-digit borrow from 10:00
    set_preset(1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, "t034_start");
    step(1'b0, 1'b0, 1'b1, "t034_tick");
    check_val("t034_0959", 32'(digits()), 32'h0959);
    repeat (59) step(1'b0, 1'b0, 1'b1, "t034_run");
    check_val("t034_0900", 32'(digits()), 32'h0900);
    step(1'b0, 1'b0, 1'b1, "t034_tick2");
    check_val("t034_0859", 32'(digits()), 32'h0859);
    step(1'b0, 1'b1, 1'b0, "t034_clear");

    // pause with simultaneous tick
    set_preset(0, 1, 3, 0);
    step(1'b1, 1'b0, 1'b0, "t035_start");
    step(1'b1, 1'b0, 1'b1, "t035_pause");
    check_val("t035_pstate", 32'(state), 32'd2);
    check_val("t035_pdig", 32'(digits()), 32'h0130);
    repeat (5) step(1'b0, 1'b0, 1'b1, "t035_hold");
    check_val("t035_hold_dig", 32'(digits()), 32'h0130);
    step(1'b1, 1'b0, 1'b0, "t035_resume");
    step(1'b0, 1'b0, 1'b1, "t035_tick");
    check_val("t035_0129", 32'(digits()), 32'h0129);
    step(1'b0, 1'b1, 1'b0, "t035_clear");

    // out-of-range preset clamping
    set_preset(7, 15, 9, 12);
    step(1'b0, 1'b0, 1'b0, "t036_idle");
    check_val("t036_7959", 32'(digits()), 32'h7959);
    step(1'b1, 1'b0, 1'b0, "t036_start");
    step(1'b0, 1'b0, 1'b1, "t036_tick");
    check_val("t036_7958", 32'(digits()), 32'h7958);
    step(1'b0, 1'b1, 1'b0, "t036_clear");

    // zero preset refuses to start
    set_preset(0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, "t037_idle");
    step(1'b1, 1'b0, 1'b0, "t037_start");
    check_val("t037_state", 32'(state), 32'd0);
    check_val("t037_done", 32'(done), 32'd0);

    // preset change ignored in run, reset mid-run, clear in done
    set_preset(0, 5, 1, 7);
    step(1'b1, 1'b0, 1'b0, "t038_start");
    set_preset(1, 2, 3, 4);
    step(1'b0, 1'b0, 1'b0, "t038_keep");
    check_val("t038_keep_dig", 32'(digits()), 32'h0517);
    do_reset("t038_rst");
    check_val("t038_rst_dig", 32'(digits()), 32'h1234);
    set_preset(0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, "t038_start2");
    step(1'b0, 1'b0, 1'b1, "t038_tick");
    check_val("t038_done", 32'(done), 32'd1);
    set_preset(1, 2, 3, 4);
    step(1'b0, 1'b0, 1'b1, "t038_done_hold");
    step(1'b0, 1'b1, 1'b0, "t038_clear");
    check_val("t038_clr_state", 32'(state), 32'd0);
    check_val("t038_clr_dig", 32'(digits()), 32'h1234);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1)
          set_preset(0, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        else
          set_preset(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
             1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
